// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one owner at a time, read/write handshake tracking,
// per-transaction timeout with a one-cycle bus_err pulse to the stalled owner.
module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [NUM_MASTERS-1:0] bus_err,
    input  logic [1:0]             bus_control,
    output logic                   park_en,
    output logic                   busy
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        GRANT      = 4'b0010,
        WAIT_RSP   = 4'b0100,
        TURNAROUND = 4'b1000
    } state_t;

    state_t                 state, state_nxt;
    logic [OW-1:0]          owner, last_owner, winner, cand;
    logic [CW-1:0]          cnt;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic                   any_req, found, tmo, err_nxt;
    int                     sum;

    assign any_req = |req;
    assign tmo     = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign busy    = (state != IDLE);
    assign park_en = (state == IDLE);

    // Search from the master after the last owner, wrapping around.
    always_comb begin
        winner = last_owner;
        found  = 1'b0;
        sum    = 0;
        cand   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            sum = int'(last_owner) + i;
            if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
            cand = OW'(sum);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_oh
        assign owner_oh[i] = (owner == OW'(i));
    end

    assign gnt = busy ? owner_oh : '0;

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (any_req) state_nxt = GRANT;
            GRANT: begin
                if (bus_control[0]) state_nxt = bus_control[1] ? WAIT_RSP : TURNAROUND;
                else if (tmo) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (bus_control[0]) state_nxt = IDLE;
                else if (tmo) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            TURNAROUND: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_MASTERS - 1);
            cnt        <= '0;
            bus_err    <= '0;
        end else begin
            state   <= state_nxt;
            bus_err <= err_nxt ? owner_oh : '0;
            if (state == IDLE && any_req) begin
                owner      <= winner;
                last_owner <= winner;
            end
            // Counter restarts on each entry to a timed state and saturates.
            if ((state_nxt == GRANT && state != GRANT) ||
                (state_nxt == WAIT_RSP && state != WAIT_RSP))
                cnt <= '0;
            else if ((state == GRANT || state == WAIT_RSP) && cnt != CW'(TIMEOUT_CYCLES))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter; expected grant lengths and owners come from
// a transaction-level model of the arbitration and timeout rules.
module tb_bus_arbiter;

    localparam int N = 4;
    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] bus_err;
    logic [1:0]   ctrl;
    logic         park_en;
    logic         busy;

    int total_n  = 0;
    int bad      = 0;
    int exp_last = N - 1;

    bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .bus_err(bus_err),
        .bus_control(ctrl), .park_en(park_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst  = 1'b1;
        req  = '0;
        ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_last = N - 1;
    endtask

    // Starts from an IDLE cycle. kind 0 = write, 1 = read; d1 = GRANT cycle of the
    // strobe (>=T means never), d2 = WAIT_RSP cycle of the response (>=T means never).
    task automatic run_txn(input logic [N-1:0] rq, input int kind, input int d1, input int d2);
        int g, w, total, win;
        bit err;
        logic [N-1:0] exp_g, one;
        win = -1;
        for (int i = 1; i <= N; i++)
            if (win < 0 && rq[(exp_last + i) % N]) win = (exp_last + i) % N;
        exp_last = win;
        one   = 1;
        exp_g = one << win;
        g = (d1 < T) ? d1 + 1 : T;
        if (d1 >= T) begin w = 0; err = 1; end
        else if (kind == 0) begin w = 1; err = 0; end
        else if (d2 < T) begin w = d2 + 1; err = 0; end
        else begin w = T; err = 1; end
        total = g + w;
        req = rq;
        for (int c = 0; c < total; c++) begin
            @(posedge clk); #1;
            total_n++;
            if (gnt !== exp_g || busy !== 1'b1 || park_en !== 1'b0 || bus_err !== '0) begin
                bad++;
                $display("FAIL txn_active c=%0d gnt=%b busy=%b park=%b err=%b want gnt=%b busy=1 park=0 err=0",
                         c, gnt, busy, park_en, bus_err, exp_g);
            end
            req = N'($urandom);
            if (c < g) ctrl = (c == d1) ? {kind == 1, 1'b1} : {1'($urandom), 1'b0};
            else if (d1 < T && kind == 1) ctrl = {1'($urandom), (c - g) == d2};
            else ctrl = 2'($urandom);
        end
        @(posedge clk); #1;
        total_n++;
        if (gnt !== '0 || busy !== 1'b0 || park_en !== 1'b1 || bus_err !== (err ? exp_g : '0)) begin
            bad++;
            $display("FAIL txn_end gnt=%b busy=%b park=%b err=%b want gnt=0 busy=0 park=1 err=%b",
                     gnt, busy, park_en, bus_err, err ? exp_g : '0);
        end
        req  = '0;
        ctrl = '0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = '1;
        ctrl = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_n++;
            if (gnt !== '0 || bus_err !== '0 || busy !== 1'b0 || park_en !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold gnt=%b err=%b busy=%b park=%b want 0/0/0/1", gnt, bus_err, busy, park_en);
            end
        end
        rst = 1'b0; req = '0; ctrl = '0; exp_last = N - 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_n++;
            if (gnt !== '0 || busy !== 1'b0 || park_en !== 1'b1) begin
                bad++;
                $display("FAIL idle_noreq gnt=%b busy=%b park=%b want 0/0/1", gnt, busy, park_en);
            end
        end
    endtask

    task automatic test_write();
        run_txn(4'b0001, 0, 0, 0);
        run_txn(4'b1000, 0, 3, 0);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(4'b1111, 0, int'($urandom_range(0, 3)), 0);
            total_n++;
            if (exp_last != i % N) begin
                bad++;
                $display("FAIL rr_order txn=%0d model_owner=%0d want %0d", i, exp_last, i % N);
            end
        end
    endtask

    task automatic test_read();
        run_txn(4'b0100, 1, 0, 4);
        run_txn(4'b0100, 1, 0, T);
        run_txn(4'b0010, 1, 15, 15);
    endtask

    task automatic test_grant_timeout();
        run_txn(4'b0010, 0, T, 0);
        run_txn(4'b0010, 0, T - 1, 0);
        run_txn(4'b0001, 1, T - 1, 0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b1111;
        @(posedge clk); #1;
        total_n++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL mid_grant gnt=%b want 0001", gnt);
        end
        ctrl = 2'b11;
        @(posedge clk); #1;
        ctrl = 2'b00;
        @(posedge clk); #1;
        total_n++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total_n++;
            if (gnt !== '0 || park_en !== 1'b1 || busy !== 1'b0 || bus_err !== '0) begin
                bad++;
                $display("FAIL mid_reset gnt=%b park=%b busy=%b err=%b want 0/1/0/0", gnt, park_en, busy, bus_err);
            end
        end
        rst = 1'b0;
        exp_last = N - 1;
        run_txn(4'b1111, 0, 0, 0);
        total_n++;
        if (exp_last != 0) begin
            bad++;
            $display("FAIL mid_first owner=%0d want 0", exp_last);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        for (int i = 0; i < 30; i++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            run_txn(rq, int'($urandom_range(0, 1)), int'($urandom_range(0, T + 1)),
                    int'($urandom_range(0, T + 1)));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) run_txn(4'b0100, i % 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_grant_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad);
        $finish;
    end

endmodule
